// File: rtl/mux4_rr_arbiter.sv
//==============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin arbiter with hold-until-release and bounded hold time,
//            producing the registered one-hot select for a 4-source bus mux.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic [1:0] grant_idx
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] c_hold_max  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       r_state;
  logic [3:0]       r_grant;
  logic             r_valid;
  logic [1:0]       r_idx;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt;

  logic [0:0]       w_state_nxt;
  logic             w_load;
  logic             w_regrant;
  logic [3:0]       w_cand;
  logic             w_found;
  logic [1:0]       w_win;
  logic [1:0]       w_pos;
  logic             w_others;
  logic             w_owner_req;
  logic             w_owner_done;
  logic             w_release;
  logic             w_force;
  logic [3:0]       w_grant_nxt;
  logic [1:0]       w_idx_nxt;
  logic [1:0]       w_last_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // While granted, the owner is masked so every search yields a different source.
  always_comb begin
    w_cand  = (r_state == S_GRANT) ? (req & ~r_grant) : req;
    w_found = 1'b0;
    w_win   = r_last;
    w_pos   = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_pos = r_last + 2'(k);
      if (!w_found && w_cand[w_pos]) begin
        w_found = 1'b1;
        w_win   = w_pos;
      end
    end
  end

  assign w_others     = |w_cand;
  assign w_owner_req  = |(req & r_grant);
  assign w_owner_done = |(done & r_grant);
  assign w_release    = !w_owner_req || w_owner_done;
  // >= so a counter already saturated rotates as soon as a contender appears.
  assign w_force      = (r_cnt >= c_hold_last) && w_others;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= 4'b0000;
      r_valid <= 1'b0;
      r_idx   <= 2'd0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= |w_grant_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_regrant   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt = S_GRANT;
          w_load      = 1'b1;
        end
      end
      S_GRANT: begin
        if ((w_release || w_force) && w_others) begin
          w_load = 1'b1;
        end else if (w_release) begin
          if (w_owner_req && w_owner_done) begin
            w_regrant = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant_nxt = r_grant;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_cnt_nxt   = (r_cnt >= c_hold_max) ? r_cnt : r_cnt + 1'b1;
    if (w_load) begin
      w_grant_nxt = 4'b0001 << w_win;
      w_idx_nxt   = w_win;
      w_last_nxt  = w_win;
      w_cnt_nxt   = '0;
    end else if (w_regrant) begin
      w_cnt_nxt   = '0;
    end else if (w_state_nxt == S_IDLE) begin
      w_grant_nxt = 4'b0000;
      w_cnt_nxt   = '0;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign grant_idx   = r_idx;

endmodule

`default_nettype wire
